// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I-subset control unit.
//  - state_t   : sequencer states (FETCH=0 .. FAULT=5), also exported on the debug port
//  - OP_*      : opcodes of the supported instruction subset
//  - ALU_*     : alu_op encodings driven to the datapath ALU control
//  - PC_*      : pc_src encodings for the PC input mux
//  - isLegalOp : true when an opcode belongs to the supported subset
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  localparam logic [2:0] ALU_LUI_JAL = 3'b000;
  localparam logic [2:0] ALU_BRANCH  = 3'b001;
  localparam logic [2:0] ALU_LOAD    = 3'b010;
  localparam logic [2:0] ALU_STORE   = 3'b011;
  localparam logic [2:0] ALU_OPIMM   = 3'b100;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Legality is decided on the opcode alone; funct3 variants inside a
  // supported opcode are left to the datapath.
  function automatic logic isLegalOp(input logic [6:0] op);
    case (op)
      OP_LUI, OP_JAL, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM: isLegalOp = 1'b1;
      default:                                               isLegalOp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Memory handshake watchdog counter.
//  Counts cycles in which a memory request is outstanding without an ack and
//  flags expiry once the count reaches LIMIT. LIMIT = 0 disables the watchdog
//  (o_expired stays 0). The count saturates at LIMIT so it never wraps back
//  below the threshold while the sequencer is still reacting to expiry.
//  LIMIT must be smaller than 2**W.
// Ports:
//  i_clk     in  1  clock, rising edge
//  i_rst_n   in  1  asynchronous active-low reset, clears the count
//  i_clear   in  1  synchronous clear (state entry or ack); wins over i_enable
//  i_enable  in  1  count this cycle (request outstanding, no ack)
//  o_expired out 1  count has reached LIMIT
module mem_timeout_cnt #(
  parameter int LIMIT = 15,
  parameter int W     = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] r_count;
  logic         w_expired;

  assign w_expired = (LIMIT != 0) && (r_count == LIMIT_W);

  // Count outstanding-request cycles; hold once expired so the flag is stable
  // until the sequencer leaves the waiting state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_expired && (LIMIT != 0)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = w_expired;

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle sequencer for the RV32I-subset datapath
// (lui, jal, bne/bge, lw, sw, addi/andi/slli).
//  Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the shared
//  instruction/data memory through a req/ack handshake and issues one-cycle
//  strobes for IR, PC and register file. Illegal opcodes and memory timeouts
//  park the sequencer in a sticky FAULT state that only reset leaves.
//  All outputs are decoded from the state register (plus opcode/comp); only
//  mem_ack acts combinationally (Mealy). Every output is forced low while
//  reset is asserted, without waiting for a clock edge.
// Configuration macro:
//  CTRL_PERF_EN  adds the cycles / instret performance counter ports.
// Parameters:
//  MEM_TIMEOUT   wait cycles tolerated before FAULT (0 disables), < 2**TMO_W
//  TMO_W         timeout counter width
// Ports:
//  clk           in   1  system clock, rising edge
//  reset         in   1  asynchronous active-low reset
//  opcode        in   7  IR[6:0], valid from DECODE onward
//  funct3        in   3  IR[14:12] (not needed for sequencing)
//  comp          in   1  ALU compare result for branches, valid in EXEC
//  mem_ack       in   1  memory finished the current request this cycle
//  mem_req       out  1  memory request
//  mem_we        out  1  memory write enable (store)
//  mem_sel_data  out  1  address mux: 0 = PC, 1 = ALU result
//  ir_write      out  1  load IR from memory read data
//  pc_write      out  1  update PC
//  pc_src        out  2  00 PC+4, 01 branch target, 10 jump target
//  reg_write     out  1  register file write strobe
//  alu_src       out  1  0 = RS2, 1 = immediate
//  mem_to_reg    out  1  0 = ALU result, 1 = load data
//  alu_op        out  3  ALU operation class
//  state         out  3  current state, debug
//  fault         out  1  sticky fault indication
//  cycles        out 32  (CTRL_PERF_EN) clocks spent outside FAULT
//  instret       out 32  (CTRL_PERF_EN) retired instructions (pc_write count)
module control_multiciclo
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        comp,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_data,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [2:0]  alu_op,
  output logic [2:0]  state,
  output logic        fault
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] cycles,
  output logic [31:0] instret
`endif
);

  state_t r_state;
  state_t w_next;

  logic       w_req;
  logic       w_we;
  logic       w_sel;
  logic       w_irWrite;
  logic       w_pcWrite;
  logic [1:0] w_pcSrc;
  logic       w_regWrite;
  logic       w_aluSrc;
  logic       w_memToReg;
  logic [2:0] w_aluOp;
  logic       w_fault;

  logic [2:0] w_opAluOp;
  logic       w_opAluSrc;

  logic       w_tmoExpired;
  logic       w_tmoClear;
  logic       w_tmoEnable;

  logic       w_unusedFunct3;

  assign w_unusedFunct3 = ^funct3;

  // Per-opcode ALU control, shared by EXEC, MEM and WB so the ALU result
  // (address or writeback value) stays stable for the whole instruction.
  always_comb begin
    w_opAluOp  = ALU_LUI_JAL;
    w_opAluSrc = 1'b0;
    case (opcode)
      OP_LUI:    begin w_opAluOp = ALU_LUI_JAL; w_opAluSrc = 1'b1; end
      OP_JAL:    begin w_opAluOp = ALU_LUI_JAL; w_opAluSrc = 1'b0; end
      OP_BRANCH: begin w_opAluOp = ALU_BRANCH;  w_opAluSrc = 1'b0; end
      OP_LOAD:   begin w_opAluOp = ALU_LOAD;    w_opAluSrc = 1'b1; end
      OP_STORE:  begin w_opAluOp = ALU_STORE;   w_opAluSrc = 1'b1; end
      OP_OPIMM:  begin w_opAluOp = ALU_OPIMM;   w_opAluSrc = 1'b1; end
      default:   ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode. A watchdog expiry is checked before
  // mem_ack so a late ack in the expiry cycle cannot complete the access.
  always_comb begin
    w_next     = r_state;
    w_req      = 1'b0;
    w_we       = 1'b0;
    w_sel      = 1'b0;
    w_irWrite  = 1'b0;
    w_pcWrite  = 1'b0;
    w_pcSrc    = PC_PLUS4;
    w_regWrite = 1'b0;
    w_aluSrc   = 1'b0;
    w_memToReg = 1'b0;
    w_aluOp    = ALU_LUI_JAL;
    w_fault    = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (w_tmoExpired) begin
          w_next = S_FAULT;
        end else if (mem_ack) begin
          w_irWrite = 1'b1;
          w_next    = S_DECODE;
        end
      end

      S_DECODE: begin
        w_next = isLegalOp(opcode) ? S_EXEC : S_FAULT;
      end

      S_EXEC: begin
        w_aluOp  = w_opAluOp;
        w_aluSrc = w_opAluSrc;
        case (opcode)
          OP_BRANCH: begin
            w_pcWrite = 1'b1;
            w_pcSrc   = comp ? PC_BRANCH : PC_PLUS4;
            w_next    = S_FETCH;
          end
          OP_JAL: begin
            w_pcWrite = 1'b1;
            w_pcSrc   = PC_JUMP;
            w_next    = S_FETCH;
          end
          OP_LOAD, OP_STORE: w_next = S_MEM;
          OP_LUI, OP_OPIMM:  w_next = S_WB;
          default:           w_next = S_FAULT;
        endcase
      end

      S_MEM: begin
        w_req    = 1'b1;
        w_sel    = 1'b1;
        w_we     = (opcode == OP_STORE);
        w_aluOp  = w_opAluOp;
        w_aluSrc = w_opAluSrc;
        if (w_tmoExpired) begin
          w_next = S_FAULT;
        end else if (mem_ack) begin
          if (opcode == OP_STORE) begin
            w_pcWrite = 1'b1;
            w_pcSrc   = PC_PLUS4;
            w_next    = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end

      S_WB: begin
        w_regWrite = 1'b1;
        w_memToReg = (opcode == OP_LOAD);
        w_pcWrite  = 1'b1;
        w_pcSrc    = PC_PLUS4;
        w_aluOp    = w_opAluOp;
        w_aluSrc   = w_opAluSrc;
        w_next     = S_FETCH;
      end

      S_FAULT: begin
        w_fault = 1'b1;
      end

      default: begin
        w_next = S_FAULT;
      end
    endcase
  end

  // The watchdog restarts on every state change and on every accepted ack,
  // and only runs while a request is outstanding.
  assign w_tmoClear  = (w_next != r_state) || (w_req && mem_ack);
  assign w_tmoEnable = w_req && !mem_ack;

  mem_timeout_cnt #(
    .LIMIT (MEM_TIMEOUT),
    .W     (TMO_W)
  ) u_tmo (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_clear   (w_tmoClear),
    .i_enable  (w_tmoEnable),
    .o_expired (w_tmoExpired)
  );

  // Reset gates every output combinationally so an in-flight memory access
  // is dropped the moment reset asserts.
  assign mem_req      = w_req      & reset;
  assign mem_we       = w_we       & reset;
  assign mem_sel_data = w_sel      & reset;
  assign ir_write     = w_irWrite  & reset;
  assign pc_write     = w_pcWrite  & reset;
  assign pc_src       = w_pcSrc    & {2{reset}};
  assign reg_write    = w_regWrite & reset;
  assign alu_src      = w_aluSrc   & reset;
  assign mem_to_reg   = w_memToReg & reset;
  assign alu_op       = w_aluOp    & {3{reset}};
  assign fault        = w_fault    & reset;
  assign state        = r_state;

`ifdef CTRL_PERF_EN
  logic [31:0] r_cycles;
  logic [31:0] r_instret;

  // Performance counters: both wrap naturally at 2**32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycles  <= '0;
      r_instret <= '0;
    end else begin
      if (r_state != S_FAULT) begin
        r_cycles <= r_cycles + 32'd1;
      end
      if (pc_write) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign cycles  = r_cycles;
  assign instret = r_instret;
`endif

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed self-checking bench for control_multiciclo.
//  Each checked cycle packs every control output into one vector and compares
//  it with a hand-written expectation. The DUT is built with MEM_TIMEOUT=4 so
//  both watchdog paths can be reached quickly. Compile with CTRL_PERF_EN to
//  also check the retired-instruction counter.
module tb_control_multiciclo;

  localparam logic [6:0] OPC_ADDI   = 7'b0010011;
  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_BNE    = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_ILLEGAL = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        comp;
  logic        memAck;
  logic        memReq;
  logic        memWe;
  logic        memSelData;
  logic        irWrite;
  logic        pcWrite;
  logic [1:0]  pcSrc;
  logic        regWrite;
  logic        aluSrc;
  logic        memToReg;
  logic [2:0]  aluOp;
  logic [2:0]  state;
  logic        fault;
`ifdef CTRL_PERF_EN
  logic [31:0] cycles;
  logic [31:0] instret;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [16:0] obsVec;

  always #5 clk = ~clk;

  control_multiciclo #(
    .MEM_TIMEOUT (4),
    .TMO_W       (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .comp         (comp),
    .mem_ack      (memAck),
    .mem_req      (memReq),
    .mem_we       (memWe),
    .mem_sel_data (memSelData),
    .ir_write     (irWrite),
    .pc_write     (pcWrite),
    .pc_src       (pcSrc),
    .reg_write    (regWrite),
    .alu_src      (aluSrc),
    .mem_to_reg   (memToReg),
    .alu_op       (aluOp),
    .state        (state),
    .fault        (fault)
`ifdef CTRL_PERF_EN
    ,
    .cycles       (cycles),
    .instret      (instret)
`endif
  );

  // Observed outputs in a fixed order:
  // {state, req, we, sel, ir, pc, pc_src, reg, alu_src, mem_to_reg, alu_op, fault}
  assign obsVec = {state, memReq, memWe, memSelData, irWrite, pcWrite, pcSrc,
                   regWrite, aluSrc, memToReg, aluOp, fault};

  function automatic logic [16:0] expVec(input int st, input int req, input int we,
                                         input int sel, input int ir, input int pc,
                                         input int src, input int rw, input int asrc,
                                         input int mtr, input int aop, input int flt);
    expVec = {3'(st), 1'(req), 1'(we), 1'(sel), 1'(ir), 1'(pc), 2'(src),
              1'(rw), 1'(asrc), 1'(mtr), 3'(aop), 1'(flt)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic c, input logic ack);
    opcode = op;
    funct3 = f3;
    comp   = c;
    memAck = ack;
  endtask

  // Compare one cycle at the falling edge, then move just past the next
  // rising edge where new stimulus is applied.
  task automatic checkCycle(input string tag, input logic [16:0] expected);
    @(negedge clk);
    checkOutput(tag, {15'b0, obsVec}, {15'b0, expected});
    @(posedge clk);
    #1;
  endtask

  // Assert reset away from the clock edge and check the outputs drop at once.
  task automatic resetAndCheck(input string tag);
    reset = 1'b0;
    #1;
    checkOutput(tag, {15'b0, obsVec}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] faultVec;
    logic [16:0] fetchWait;
    logic [16:0] lwMem;
    faultVec  = expVec(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    fetchWait = expVec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lwMem     = expVec(3, 1, 0, 1, 0, 0, 0, 0, 1, 0, 3'b010, 0);

    $display("[TB] start");
    reset = 1'b0;
    applyStimulus(7'd0, 3'd0, 1'b0, 1'b1);

    // Reset held with ack high: nothing may move.
    for (int i = 0; i < 3; i++) checkCycle("reset idle", 17'd0);
    applyStimulus(OPC_ADDI, 3'b000, 1'b0, 1'b0);
    reset = 1'b1;
    checkCycle("release fetch", fetchWait);

    // addi, zero-wait: F D E W; ack held high to show it is ignored without req.
    applyStimulus(OPC_ADDI, 3'b000, 1'b0, 1'b1);
    checkCycle("addi F", expVec(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    checkCycle("addi D", expVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkCycle("addi E", expVec(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b100, 0));
    checkCycle("addi W", expVec(4, 0, 0, 0, 0, 1, 0, 1, 1, 0, 3'b100, 0));

    // lw with 2 fetch waits and 3 data waits: 10 cycles.
    applyStimulus(OPC_LW, 3'b010, 1'b0, 1'b0);
    checkCycle("lw F wait1", fetchWait);
    checkCycle("lw F wait2", fetchWait);
    applyStimulus(OPC_LW, 3'b010, 1'b0, 1'b1);
    checkCycle("lw F ack", expVec(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(OPC_LW, 3'b010, 1'b0, 1'b0);
    checkCycle("lw D", expVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkCycle("lw E", expVec(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b010, 0));
    for (int i = 0; i < 3; i++) checkCycle("lw M wait", lwMem);
    applyStimulus(OPC_LW, 3'b010, 1'b0, 1'b1);
    checkCycle("lw M ack", lwMem);
    applyStimulus(OPC_LW, 3'b010, 1'b0, 1'b0);
    checkCycle("lw W", expVec(4, 0, 0, 0, 0, 1, 0, 1, 1, 1, 3'b010, 0));

    // bne taken.
    applyStimulus(OPC_BNE, 3'b001, 1'b1, 1'b1);
    checkCycle("bne1 F", expVec(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    checkCycle("bne1 D", expVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkCycle("bne1 E", expVec(2, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 3'b001, 0));
`ifdef CTRL_PERF_EN
    checkOutput("instret after 3", instret, 32'd3);
`endif

    // bne not taken.
    applyStimulus(OPC_BNE, 3'b001, 1'b0, 1'b1);
    checkCycle("bne0 F", expVec(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    checkCycle("bne0 D", expVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkCycle("bne0 E", expVec(2, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 3'b001, 0));

    // jal: jump target, no register write.
    applyStimulus(OPC_JAL, 3'b000, 1'b0, 1'b1);
    checkCycle("jal F", expVec(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    checkCycle("jal D", expVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkCycle("jal E", expVec(2, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 3'b000, 0));

    // sw with one data wait: we held, pc_write only on ack.
    applyStimulus(OPC_SW, 3'b010, 1'b0, 1'b1);
    checkCycle("sw F", expVec(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(OPC_SW, 3'b010, 1'b0, 1'b0);
    checkCycle("sw D", expVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkCycle("sw E", expVec(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b011, 0));
    checkCycle("sw M wait", expVec(3, 1, 1, 1, 0, 0, 0, 0, 1, 0, 3'b011, 0));
    applyStimulus(OPC_SW, 3'b010, 1'b0, 1'b1);
    checkCycle("sw M ack", expVec(3, 1, 1, 1, 0, 1, 0, 0, 1, 0, 3'b011, 0));
`ifdef CTRL_PERF_EN
    checkOutput("instret after 6", instret, 32'd6);
`endif

    // lw whose data access times out; a late ack in the expiry cycle loses.
    applyStimulus(OPC_LW, 3'b010, 1'b0, 1'b1);
    checkCycle("tmoM F", expVec(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(OPC_LW, 3'b010, 1'b0, 1'b0);
    checkCycle("tmoM D", expVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkCycle("tmoM E", expVec(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b010, 0));
    for (int i = 0; i < 4; i++) checkCycle("tmoM wait", lwMem);
    applyStimulus(OPC_LW, 3'b010, 1'b0, 1'b1);
    checkCycle("tmoM late ack", lwMem);
    checkCycle("tmoM fault1", faultVec);
    checkCycle("tmoM fault2", faultVec);
    applyStimulus(OPC_ADDI, 3'b000, 1'b0, 1'b0);
    resetAndCheck("reset after tmoM");

    // Fetch timeout: 4 waits, then expiry cycle ignoring a late ack.
    reset = 1'b1;
    for (int i = 0; i < 4; i++) checkCycle("tmoF wait", fetchWait);
    applyStimulus(OPC_ADDI, 3'b000, 1'b0, 1'b1);
    checkCycle("tmoF late ack", fetchWait);
    checkCycle("tmoF fault", faultVec);
    resetAndCheck("reset after tmoF");

    // Illegal opcode: FAULT after DECODE, sticky for 20 cycles.
    applyStimulus(OPC_ILLEGAL, 3'b000, 1'b0, 1'b1);
    reset = 1'b1;
    checkCycle("ill F", expVec(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    checkCycle("ill D", expVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      applyStimulus(OPC_ILLEGAL, 3'b000, 1'(i), 1'(i >> 1));
      checkCycle("ill sticky", faultVec);
    end
    resetAndCheck("reset after ill");

    // Reset in the middle of a store wait drops the request without a clock edge.
    applyStimulus(OPC_SW, 3'b010, 1'b0, 1'b1);
    reset = 1'b1;
    checkCycle("swr F", expVec(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(OPC_SW, 3'b010, 1'b0, 1'b0);
    checkCycle("swr D", expVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkCycle("swr E", expVec(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b011, 0));
    checkCycle("swr M wait", expVec(3, 1, 1, 1, 0, 0, 0, 0, 1, 0, 3'b011, 0));
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst mid MEM req", {31'b0, memReq}, 32'd0);
    checkOutput("rst mid MEM we", {31'b0, memWe}, 32'd0);
    checkOutput("rst mid MEM state", {29'b0, state}, 32'd0);
`ifdef CTRL_PERF_EN
    checkOutput("instret cleared", instret, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(OPC_ADDI, 3'b000, 1'b0, 1'b0);
    checkCycle("after reset fetch", fetchWait);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
